// File: rtl/l2_pkg.sv
// Shared constants and types for the L2-norm square-root stage.
package l2_pkg;

  localparam int L2_IN_W  = 20;
  localparam int L2_OUT_W = L2_IN_W / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } l2_state_t;

  typedef struct packed {
    logic               ovf;
    logic [L2_IN_W-1:0] sum;
  } l2_entry_t;

endpackage

// File: rtl/l2_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is taken only when a pop frees a slot on the same edge.
// Latency: one cycle from push to visible on rd_data; full/empty come straight from the occupancy register.
module l2_sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/l2_sqrt_stage.sv
// Floor square root with remainder of buffered sums, restoring algorithm at one root bit per cycle.
// Latency 11 cycles, one result per 11 cycles; no backpressure upstream, overflowing inputs set sticky drop.
module l2_sqrt_stage
  import l2_pkg::*;
#(
  parameter int IN_W       = L2_IN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   f_in,
  input  logic              ovf_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [IN_W/2-1:0] root,
  output logic [IN_W/2:0]   rem,
  output logic              valid_out,
  output logic              ovf_out,
  output logic              drop
);

  localparam int OUT_W = IN_W / 2;
  localparam int CNT_W = $clog2(OUT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  l2_state_t        state, state_nx;
  l2_entry_t        wr_entry, rd_entry;
  logic             full, empty, pop, push, last;
  logic [IN_W-1:0]  rad_q;
  logic [OUT_W-1:0] root_q, root_nx;
  logic [OUT_W:0]   rem_q, rem_nx;
  logic [OUT_W+2:0] rem_sh, sub, trial;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;

  assign wr_entry = '{ovf: ovf_in, sum: f_in};
  assign push     = valid_in && (!full || pop);
  assign in_ready = !full;
  assign last     = (state == CALC) && (cnt == CNT_LAST);

  l2_sync_fifo #(.WIDTH($bits(l2_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty)
  );

  // Trial subtraction; the top bit of trial is its sign.
  assign rem_sh  = {rem_q, rad_q[IN_W-1 -: 2]};
  assign sub     = {1'b0, root_q, 2'b01};
  assign trial   = rem_sh - sub;
  assign root_nx = {root_q[OUT_W-2:0], ~trial[OUT_W+2]};
  assign rem_nx  = trial[OUT_W+2] ? rem_sh[OUT_W:0] : trial[OUT_W:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop      = 1'b1;
        state_nx = CALC;
      end
      CALC: if (cnt == CNT_LAST) state_nx = DONE;
      DONE: begin
        pop      = !empty;
        state_nx = empty ? IDLE : CALC;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rad_q     <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      root      <= '0;
      rem       <= '0;
      ovf_out   <= 1'b0;
      valid_out <= 1'b0;
      drop      <= 1'b0;
    end else begin
      valid_out <= last;
      if (valid_in && full && !pop) drop <= 1'b1;
      if (pop) begin
        rad_q  <= rd_entry.sum;
        ovf_q  <= rd_entry.ovf;
        root_q <= '0;
        rem_q  <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        rad_q  <= rad_q << 2;
        root_q <= root_nx;
        rem_q  <= rem_nx;
        cnt    <= cnt + 1'b1;
      end
      if (last) begin
        root    <= ovf_q ? '1 : root_nx;
        rem     <= ovf_q ? '0 : rem_nx;
        ovf_out <= ovf_q;
      end
    end
  end

endmodule
